aes_key_expander: RTL and testbench

Parameterised AES key schedule supporting AES-128, AES-192 and AES-256, selected per operation. It expands a cipher key one 32-bit word per cycle and delivers round keys 0..Nr as 128-bit words over a valid/ready stream, buffered in a small output FIFO. It sits between the key-load path and the round datapath and replaces the fixed AES-256, free-running round-key generator.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_sbox.sv | 37 +++
 rtl/aes_key_expander.sv | 144 ++++++++++++++
 tb/tb_aes_key_expander.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES key schedule: key-length encodings,
// FSM states, the round-key FIFO entry, and small word/byte functions.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128  = 2'b00,
        KEY_192  = 2'b01,
        KEY_256  = 2'b10,
        KEY_RSVD = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   index;
        logic         last;
    } rk_entry_t;

    function automatic logic [3:0] nk(input logic [1:0] kl);
        case (kl)
            KEY_128: return 4'd4;
            KEY_192: return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr(input logic [1:0] kl);
        case (kl)
            KEY_128: return 4'd10;
            KEY_192: return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (as x^254) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] subst
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign subst = sbox(value);

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule: one 32-bit word per cycle, round keys
// collected into 128-bit entries and streamed out through a small FIFO.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int RK_FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] init_key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last,
    output logic         busy,
    output logic         err
);

    localparam int PW = (RK_FIFO_DEPTH > 1) ? $clog2(RK_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(RK_FIFO_DEPTH + 1);

    state_e         state, state_nxt;
    logic [5:0]     j, last_j;
    logic [2:0]     jmod;
    logic [3:0]     nk_r;
    logic [7:0]     rcon;
    logic [255:0]   key_r;
    logic [31:0]    win [8];
    logic [31:0]    col [3];
    rk_entry_t      fifo [RK_FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;

    logic           accept, bad, full, pop, stall, advance, push;
    logic           in_key, rot_step, sub_step;
    logic [31:0]    prev, back, sub_in, sub_out, temp, w_new;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RK_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Word generator: w[j] from the window (w[j-1] at win[7], w[j-Nk] at win[8-Nk])
    assign prev     = win[7];
    assign back     = win[3'(4'd8 - nk_r)];
    assign in_key   = j < {2'b00, nk_r};
    assign rot_step = !in_key && (jmod == 3'd0);
    assign sub_step = !in_key && (nk_r == 4'd8) && (jmod == 3'd4);
    assign sub_in   = rot_step ? rotword(prev) : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (.value(sub_in[8*b +: 8]), .subst(sub_out[8*b +: 8]));
    end

    assign temp  = rot_step ? (sub_out ^ {rcon, 24'h0}) : (sub_step ? sub_out : prev);
    assign w_new = in_key ? key_r[255:224] : (back ^ temp);

    // FSM outputs and handshake qualifiers
    always_comb begin
        busy    = (state != ST_IDLE) || (count != '0);
        accept  = start && !busy && (key_len != KEY_RSVD);
        bad     = start && !busy && (key_len == KEY_RSVD);
        full    = (count == CW'(RK_FIFO_DEPTH));
        pop     = rk_valid && rk_ready;
        stall   = (state == ST_EXPAND) && (j[1:0] == 2'd3) && full && !pop;
        advance = (state == ST_EXPAND) && !stall;
        push    = advance && (j[1:0] == 2'd3);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_EXPAND;
            ST_EXPAND: if (advance && (j == last_j)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if ((count == '0) || ((count == CW'(1)) && pop)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j      <= '0;
            jmod   <= '0;
            last_j <= '0;
            nk_r   <= 4'd4;
            rcon   <= 8'h01;
            key_r  <= '0;
            err    <= 1'b0;
            for (int i = 0; i < 8; i++) win[i] <= '0;
            for (int i = 0; i < 3; i++) col[i] <= '0;
        end else begin
            err <= bad;
            if (accept) begin
                j      <= '0;
                jmod   <= '0;
                rcon   <= 8'h01;
                nk_r   <= nk(key_len);
                last_j <= {4'(nr(key_len) + 4'd1), 2'b00} - 6'd1;
                key_r  <= init_key;
            end else if (advance) begin
                j     <= j + 6'd1;
                jmod  <= (jmod == 3'(nk_r - 4'd1)) ? 3'd0 : jmod + 3'd1;
                key_r <= {key_r[223:0], 32'h0};
                if (rot_step) rcon <= xtime(rcon);
                for (int i = 0; i < 7; i++) win[i] <= win[i+1];
                win[7] <= w_new;
                if (j[1:0] != 2'd3) col[j[1:0]] <= w_new;
            end
        end
    end

    // Round-key FIFO: circular buffer, push and pop may share an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RK_FIFO_DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{data:  {col[0], col[1], col[2], w_new},
                                  index: j[5:2],
                                  last:  (j == last_j)};
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign rk_valid = (count != '0);
    assign rk_data  = fifo[rd_ptr].data;
    assign rk_index = fifo[rd_ptr].index;
    assign rk_last  = fifo[rd_ptr].last;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key schedule vectors.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready;
    logic [1:0]   key_len;
    logic [255:0] init_key;
    logic         rk_valid, rk_last, busy, err;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;

    aes_key_expander #(.RK_FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len),
        .init_key(init_key), .rk_ready(rk_ready), .rk_valid(rk_valid),
        .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] IK128 = {K128, 128'hdeadbeef_cafef00d_01234567_89abcdef};
    localparam logic [255:0] IK192 = {K192, 64'hffff0000_ffff0000};

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        int           r;
        logic [127:0] exp_data;
        logic         exp_last;
        int           nkeys;
    } vec_t;

    vec_t vecs [9];

    int           checks = 0;
    int           errors = 0;
    logic [127:0] cap_data [16];
    logic [3:0]   cap_idx  [16];
    logic         cap_last [16];
    int           cap_cyc  [16];
    int           cap_n, err_seen, hold_bad;
    logic         timed_out, busy_at_start;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rk_valid"}, 128'(rk_valid), 128'd0);
        chk({tag, " rk_data"},  rk_data,         128'd0);
        chk({tag, " rk_index"}, 128'(rk_index), 128'd0);
        chk({tag, " rk_last"},  128'(rk_last),  128'd0);
        chk({tag, " busy"},     128'(busy),     128'd0);
        chk({tag, " err"},      128'(err),      128'd0);
    endtask

    // rmode 0: ready always high; 1: ready low for 30 cycles then random.
    // inject_at: cycle at which a second start is driven while busy.
    // abort_idx: return as soon as that round key is visible.
    task automatic run(input logic [1:0] kl, input logic [255:0] key, input int rmode,
                       input int inject_at, input int abort_idx);
        logic         pv, pr, pl;
        logic [127:0] pd;
        logic [3:0]   pi;
        cap_n = 0; err_seen = 0; hold_bad = 0; timed_out = 1'b0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pi = '0;
        rk_ready = (rmode == 0);
        @(negedge clk);
        start = 1'b1; key_len = kl; init_key = key;
        @(posedge clk); #1;
        start = 1'b0;
        init_key = ~key;
        busy_at_start = busy;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (cyc == inject_at) begin
                start = 1'b1; key_len = 2'b10; init_key = {8{32'h5a5a5a5a}};
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (err) err_seen++;
            if (!busy) return;
            if (pv && !pr && (!rk_valid || rk_data !== pd || rk_index !== pi || rk_last !== pl))
                hold_bad++;
            if (rmode == 1) rk_ready = (cyc >= 30) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rk_valid && rk_ready) begin
                if (cap_n < 16) begin
                    cap_data[cap_n] = rk_data;
                    cap_idx[cap_n]  = rk_index;
                    cap_last[cap_n] = rk_last;
                    cap_cyc[cap_n]  = cyc;
                end
                cap_n++;
            end
            if (abort_idx >= 0 && rk_valid && int'(rk_index) == abort_idx) return;
            pv = rk_valid; pr = rk_ready; pd = rk_data; pi = rk_index; pl = rk_last;
        end
        timed_out = 1'b1;
    endtask

    task automatic chk_order(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n && i < 16; i++) begin
            if (int'(cap_idx[i]) != i) bad++;
            if (cap_last[i] !== (i == n - 1)) bad++;
        end
        chk(name, 128'(bad), 128'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, IK128, 0,  K128, 1'b0, 11};
        vecs[1] = '{2'b00, IK128, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 11};
        vecs[2] = '{2'b00, IK128, 2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0, 11};
        vecs[3] = '{2'b00, IK128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 11};
        vecs[4] = '{2'b01, IK192, 0,  K192[191:64], 1'b0, 13};
        vecs[5] = '{2'b01, IK192, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b0, 13};
        vecs[6] = '{2'b01, IK192, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b1, 13};
        vecs[7] = '{2'b10, K256,  1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b0, 15};
        vecs[8] = '{2'b10, K256,  14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1, 15};

        rst_n = 1'b0; start = 1'b0; key_len = 2'b00; init_key = '0; rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running expansions, one vector per run
        for (int v = 0; v < 9; v++) begin
            run(vecs[v].kl, vecs[v].key, 0, -1, -1);
            chk($sformatf("v%0d timeout", v), 128'(timed_out), 128'd0);
            chk($sformatf("v%0d busy after start", v), 128'(busy_at_start), 128'd1);
            chk($sformatf("v%0d key count", v), 128'(cap_n), 128'(vecs[v].nkeys));
            chk($sformatf("v%0d rk%0d data", v, vecs[v].r), cap_data[vecs[v].r], vecs[v].exp_data);
            chk($sformatf("v%0d rk%0d index", v, vecs[v].r), 128'(cap_idx[vecs[v].r]), 128'(vecs[v].r));
            chk($sformatf("v%0d rk%0d last", v, vecs[v].r), 128'(cap_last[vecs[v].r]), 128'(vecs[v].exp_last));
            chk($sformatf("v%0d rk%0d latency", v, vecs[v].r), 128'(cap_cyc[vecs[v].r]), 128'(4 * vecs[v].r + 4));
        end

        // Backpressure: consumer stalls for 30 cycles, then random ready
        run(2'b10, K256, 1, -1, -1);
        chk("bp timeout", 128'(timed_out), 128'd0);
        chk("bp key count", 128'(cap_n), 128'd15);
        chk_order("bp order", 15);
        chk("bp hold stable", 128'(hold_bad), 128'd0);
        chk("bp first pop after stall", 128'(cap_cyc[0] >= 30), 128'd1);
        chk("bp rk0", cap_data[0], K256[255:128]);
        chk("bp rk1", cap_data[1], K256[127:0]);
        chk("bp rk2", cap_data[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("bp rk14", cap_data[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Reserved key length: err pulse only
        @(negedge clk);
        start = 1'b1; key_len = 2'b11; init_key = K256;
        @(posedge clk); #1;
        start = 1'b0;
        chk("bad start err", 128'(err), 128'd1);
        chk("bad start busy", 128'(busy), 128'd0);
        @(posedge clk); #1;
        chk("bad start err clears", 128'(err), 128'd0);
        chk("bad start busy stays", 128'(busy), 128'd0);

        // Start while busy is ignored
        run(2'b00, IK128, 0, 10, -1);
        chk("inject timeout", 128'(timed_out), 128'd0);
        chk("inject key count", 128'(cap_n), 128'd11);
        chk_order("inject order", 11);
        chk("inject rk0", cap_data[0], K128);
        chk("inject rk10", cap_data[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("inject no err", 128'(err_seen), 128'd0);
        chk("inject rk10 latency", 128'(cap_cyc[10]), 128'd44);

        // Reset mid-run after rk5, then a clean AES-256 run
        run(2'b00, IK128, 0, -1, 5);
        chk("abort reached rk5", 128'(timed_out), 128'd0);
        chk("abort rk5 data", 128'(rk_index), 128'd5);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun reset");
        @(posedge clk); #1;
        chk_reset_outputs("midrun reset held");
        @(negedge clk);
        rst_n = 1'b1;
        run(2'b10, K256, 0, -1, -1);
        chk("post reset timeout", 128'(timed_out), 128'd0);
        chk("post reset key count", 128'(cap_n), 128'd15);
        chk_order("post reset order", 15);
        chk("post reset rk0", cap_data[0], K256[255:128]);
        chk("post reset rk2", cap_data[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("post reset rk14", cap_data[14], 128'hfe4890d1e6188d0b046df344706c631e);
        chk("post reset rk0 latency", 128'(cap_cyc[0]), 128'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
